// File: rtl/bfis_pkg.sv
// Shared constants, state type and helpers for the bfis search-core front end.
package bfis_pkg;

    localparam logic [31:0] SENTINEL_DEFAULT = 32'hFFFF_FFFF;
    localparam int unsigned K_WIDTH          = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ISSUE,
        WAIT
    } qload_state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/query_loader_if.sv
// Host word stream and bfis launch/return signals of the query loader.
interface query_loader_if #(
    parameter int unsigned DIM = 4
);
    logic [31:0] word_in;
    logic        word_valid_in;
    logic        word_ready_out;
    logic        search_done_in;
    logic [31:0] query_out [DIM-1:0];
    logic [15:0] k_out;
    logic [31:0] vertex_id_out;
    logic        valid_out;
    logic        frame_err_out;
    logic        busy_out;
    logic [31:0] cycles_out;

    modport slave (
        input  word_in, word_valid_in, search_done_in,
        output word_ready_out, query_out, k_out, vertex_id_out,
        output valid_out, frame_err_out, busy_out, cycles_out
    );

    modport master (
        output word_in, word_valid_in, search_done_in,
        input  word_ready_out, query_out, k_out, vertex_id_out,
        input  valid_out, frame_err_out, busy_out, cycles_out
    );
endinterface

// File: rtl/query_loader.sv
// Deframes the host word stream into one bfis query and holds it until the search ends.
// Optional macro QLOAD_CYCLE_COUNT_EN adds a launch-to-done latency counter on cycles_out.
module query_loader
    import bfis_pkg::*;
#(
    parameter int unsigned DIM      = 4,
    parameter logic [31:0] SENTINEL = SENTINEL_DEFAULT
) (
    input logic           clk_in,
    input logic           rst_in,
    query_loader_if.slave bus
);
    localparam int unsigned      IDX_W   = $clog2(DIM + 2);
    localparam logic [IDX_W-1:0] IDX_K   = IDX_W'(DIM);
    localparam logic [IDX_W-1:0] IDX_VID = IDX_W'(DIM + 1);

    qload_state_t     state, state_nx;
    logic [IDX_W-1:0] idx;
    logic [31:0]      stg_query [DIM-1:0];
    logic [31:0]      stg_k;
    logic             accept, is_sentinel, last_word, k_bad;

    always_comb begin
        accept      = bus.word_valid_in && (state == IDLE || state == LOAD);
        is_sentinel = (bus.word_in == SENTINEL);
        last_word   = accept && !is_sentinel && state == LOAD && idx == IDX_VID;
        k_bad       = (stg_k[31:K_WIDTH] != '0) || (stg_k[K_WIDTH-1:0] == '0);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx           = state;
        bus.word_ready_out = 1'b0;
        bus.valid_out      = 1'b0;
        bus.busy_out       = 1'b0;
        unique case (state)
            IDLE: begin
                bus.word_ready_out = 1'b1;
                if (accept && is_sentinel) state_nx = LOAD;
            end
            LOAD: begin
                bus.word_ready_out = 1'b1;
                if (last_word) state_nx = k_bad ? IDLE : ISSUE;
            end
            ISSUE: begin
                bus.valid_out = 1'b1;
                bus.busy_out  = 1'b1;
                state_nx      = WAIT;
            end
            WAIT: begin
                bus.busy_out = 1'b1;
                if (bus.search_done_in) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs load straight from staging (vid from the live word) on the accepting edge,
    // so they are already stable in the ISSUE cycle.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            idx               <= '0;
            stg_k             <= '0;
            bus.k_out         <= '0;
            bus.vertex_id_out <= '0;
            bus.frame_err_out <= 1'b0;
            for (int unsigned i = 0; i < DIM; i++) begin
                stg_query[i]     <= '0;
                bus.query_out[i] <= '0;
            end
        end else begin
            bus.frame_err_out <= 1'b0;
            if (accept && is_sentinel) begin
                idx <= '0;
                if (state == LOAD) bus.frame_err_out <= 1'b1;
            end else if (accept && state == LOAD) begin
                for (int unsigned i = 0; i < DIM; i++)
                    if (idx == IDX_W'(i)) stg_query[i] <= bus.word_in;
                if (idx == IDX_K) stg_k <= bus.word_in;
                if (last_word) begin
                    idx <= '0;
                    if (k_bad) begin
                        bus.frame_err_out <= 1'b1;
                    end else begin
                        bus.query_out     <= stg_query;
                        bus.k_out         <= stg_k[K_WIDTH-1:0];
                        bus.vertex_id_out <= bus.word_in;
                    end
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

`ifdef QLOAD_CYCLE_COUNT_EN
    logic [31:0] cycle_cnt, cycles_q;

    // The done cycle itself is a WAIT cycle, so the reported count includes it.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cycle_cnt <= '0;
            cycles_q  <= '0;
        end else if (state == ISSUE) begin
            cycle_cnt <= '0;
        end else if (state == WAIT) begin
            cycle_cnt <= sat_inc(cycle_cnt);
            if (bus.search_done_in) cycles_q <= sat_inc(cycle_cnt);
        end
    end

    assign bus.cycles_out = cycles_q;
`else
    assign bus.cycles_out = '0;
`endif

endmodule

// File: tb/tb_query_loader.sv
// Self-checking bench for query_loader (DIM=4): frame-level reference model plus directed frames.
module tb_query_loader;
    localparam int unsigned DIM = 4;
    localparam logic [31:0] SENT = 32'hFFFF_FFFF;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    int   checks = 0;
    int   errors = 0;

    query_loader_if #(.DIM(DIM)) bus();

    query_loader #(.DIM(DIM), .SENTINEL(SENT)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is a queue of payload words collected after a sentinel.
    bit          m_in_frame = 0, m_launch = 0, m_wait = 0, exp_err = 0;
    logic [31:0] m_frame [$];
    logic [31:0] exp_q [DIM];
    logic [31:0] exp_k = '0, exp_vid = '0, exp_cycles = '0;
    int unsigned tcyc = 0, vcyc = 0;

    initial foreach (exp_q[i]) exp_q[i] = '0;

    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            m_in_frame = 0; m_launch = 0; m_wait = 0; exp_err = 0;
            m_frame.delete();
            foreach (exp_q[i]) exp_q[i] = '0;
            exp_k = '0; exp_vid = '0; exp_cycles = '0;
        end else begin
            exp_err = 0;
            if (m_launch) begin
                m_launch = 0;
                m_wait   = 1;
            end else if (m_wait) begin
                if (bus.search_done_in) begin
                    m_wait = 0;
`ifdef QLOAD_CYCLE_COUNT_EN
                    exp_cycles = tcyc - vcyc;
`endif
                end
            end else if (bus.word_valid_in) begin
                if (bus.word_in == SENT) begin
                    if (m_in_frame) exp_err = 1;
                    m_in_frame = 1;
                    m_frame.delete();
                end else if (m_in_frame) begin
                    m_frame.push_back(bus.word_in);
                    if (m_frame.size() == DIM + 2) begin
                        m_in_frame = 0;
                        if (m_frame[DIM] < 1 || m_frame[DIM] > 32'h0000_FFFF) begin
                            exp_err = 1;
                        end else begin
                            for (int i = 0; i < DIM; i++) exp_q[i] = m_frame[i];
                            exp_k    = m_frame[DIM];
                            exp_vid  = m_frame[DIM+1];
                            m_launch = 1;
                            vcyc     = tcyc + 1;
                        end
                    end
                end
            end
            tcyc++;
        end
    end

    always @(negedge clk_in) begin
        chk("ready", {31'b0, bus.word_ready_out}, {31'b0, !(m_launch || m_wait)});
        chk("valid", {31'b0, bus.valid_out}, {31'b0, m_launch});
        chk("busy", {31'b0, bus.busy_out}, {31'b0, m_launch || m_wait});
        chk("frame_err", {31'b0, bus.frame_err_out}, {31'b0, exp_err});
        for (int i = 0; i < DIM; i++) chk($sformatf("query[%0d]", i), bus.query_out[i], exp_q[i]);
        chk("k", {16'b0, bus.k_out}, exp_k);
        chk("vid", bus.vertex_id_out, exp_vid);
        chk("cycles", bus.cycles_out, exp_cycles);
    end

    task automatic tick();
        @(posedge clk_in);
        #2;
    endtask

    task automatic send(input logic [31:0] w);
        bus.word_in       = w;
        bus.word_valid_in = 1'b1;
        tick();
        bus.word_valid_in = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] k, input logic [31:0] vid,
                              input logic [31:0] q0, q1, q2, q3);
        send(SENT); send(q0); send(q1); send(q2); send(q3); send(k); send(vid);
    endtask

    task automatic wait_valid();
        for (int n = 0; n < 8 && !bus.valid_out; n++) tick();
        chk("launch_seen", {31'b0, bus.valid_out}, 32'd1);
    endtask

    task automatic finish_search(input int n);
        repeat (n) tick();
        bus.search_done_in = 1'b1;
        tick();
        bus.search_done_in = 1'b0;
    endtask

    task automatic chk_query(input string tag, input logic [31:0] q0, q1, q2, q3,
                             input logic [31:0] k, input logic [31:0] vid);
        chk({tag, "_q0"}, bus.query_out[0], q0);
        chk({tag, "_q1"}, bus.query_out[1], q1);
        chk({tag, "_q2"}, bus.query_out[2], q2);
        chk({tag, "_q3"}, bus.query_out[3], q3);
        chk({tag, "_k"}, {16'b0, bus.k_out}, k);
        chk({tag, "_vid"}, bus.vertex_id_out, vid);
    endtask

    initial begin
        bus.word_in = '0; bus.word_valid_in = 1'b0; bus.search_done_in = 1'b0;
        repeat (3) tick();
        chk("rst_ready", {31'b0, bus.word_ready_out}, 32'd1);
        chk("rst_busy", {31'b0, bus.busy_out}, 32'd0);
        chk_query("rst", 0, 0, 0, 0, 0, 0);
        rst_in = 1'b0;
        tick();

        // Basic launch, then host holds a word during WAIT, done 37 cycles after launch
        send_frame(4, 1, 5, 7, 1, 1);
        chk("a_valid_next", {31'b0, bus.valid_out}, 32'd1);
        chk("a_busy", {31'b0, bus.busy_out}, 32'd1);
        chk_query("a", 5, 7, 1, 1, 4, 1);
        for (int i = 0; i < 37; i++) begin
            bus.word_in = SENT;
            bus.word_valid_in = (i < 20);
            if (i == 10) chk("a_wait_ready", {31'b0, bus.word_ready_out}, 32'd0);
            tick();
        end
        bus.word_valid_in = 1'b0;
        bus.search_done_in = 1'b1;
        tick();
        bus.search_done_in = 1'b0;
        chk("a_ready_after_done", {31'b0, bus.word_ready_out}, 32'd1);
`ifdef QLOAD_CYCLE_COUNT_EN
        chk("a_cycles", bus.cycles_out, 32'd37);
`else
        chk("a_cycles", bus.cycles_out, 32'd0);
`endif

        // Stray done in IDLE, then resync on a mid-frame sentinel
        finish_search(1);
        send(SENT); send(5); send(7); send(SENT);
        chk("b_err_pulse", {31'b0, bus.frame_err_out}, 32'd1);
        send(2); send(2); send(2); send(2); send(3); send(9);
        wait_valid();
        chk_query("b", 2, 2, 2, 2, 3, 9);
        finish_search(4);

        // Illegal k values drop the frame and keep prior outputs
        send_frame(0, 8, 1, 2, 3, 4);
        chk("c_err_pulse", {31'b0, bus.frame_err_out}, 32'd1);
        chk("c_no_valid", {31'b0, bus.valid_out}, 32'd0);
        send_frame(32'h0001_0004, 8, 1, 2, 3, 4);
        chk("d_err_pulse", {31'b0, bus.frame_err_out}, 32'd1);
        repeat (2) tick();
        chk_query("d_held", 2, 2, 2, 2, 3, 9);
        chk("d_ready", {31'b0, bus.word_ready_out}, 32'd1);

        // Async reset mid-LOAD, garbage, then a clean frame with maximum k
        send(SENT); send(11); send(12);
        #1 rst_in = 1'b1;
        #1 chk_query("rl", 0, 0, 0, 0, 0, 0);
        chk("rl_ready", {31'b0, bus.word_ready_out}, 32'd1);
        @(posedge clk_in); #2 rst_in = 1'b0;
        send(3); send(4); send(13); send(14);
        send_frame(32'h0000_FFFF, 5, 9, 8, 7, 6);
        chk_query("e", 9, 8, 7, 6, 32'h0000_FFFF, 5);

        // Async reset mid-WAIT, then a clean frame launches
        repeat (3) tick();
        #1 rst_in = 1'b1;
        #1 chk("rw_busy", {31'b0, bus.busy_out}, 32'd0);
        chk_query("rw", 0, 0, 0, 0, 0, 0);
        @(posedge clk_in); #2 rst_in = 1'b0;
        send(32'h1234_5678);
        send_frame(2, 32'hDEAD_BEEF, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 32'h0000_0040);
        chk_query("f", 32'h10, 32'h20, 32'h30, 32'h40, 2, 32'hDEAD_BEEF);
        finish_search(5);
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
